// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
//   Types and constants shared by the FPU top level and its issue front-end.
//   - fpu_op_e  : opcode carried on sel (add, sub, mul, div)
//   - fpu_rnd_e : IEEE-754 rounding mode carried on round_mode
//   - fpu_req_t : one FPU operation request {a, b, sel, round}
// ---------------------------------------------------------------------------
package fpu_pkg;

  typedef enum logic [1:0] {
    FPU_OP_ADD = 2'd0,
    FPU_OP_SUB = 2'd1,
    FPU_OP_MUL = 2'd2,
    FPU_OP_DIV = 2'd3
  } fpu_op_e;

  typedef enum logic [1:0] {
    FPU_RND_NEAREST_EVEN = 2'd0,
    FPU_RND_TO_ZERO      = 2'd1,
    FPU_RND_UP           = 2'd2,
    FPU_RND_DOWN         = 2'd3
  } fpu_rnd_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    fpu_op_e     sel;
    fpu_rnd_e    round;
  } fpu_req_t;

endpackage

// File: rtl/fpu_req_fifo.sv
// ---------------------------------------------------------------------------
// fpu_req_fifo
//   Synchronous FIFO of FPU requests plus requester tag.
//   A push is taken only when the FIFO is not full (a full FIFO rejects the
//   push even if it is popped in the same cycle); a pop is taken only when
//   non-empty. Head fields are valid whenever empty is low.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   push, push_req,      write strobe, request and tag to store
//   push_tag
//   pop                  advance the head
//   head_req, head_tag   oldest stored entry
//   full, empty, count   occupancy status (count is 0..DEPTH)
// ---------------------------------------------------------------------------
module fpu_req_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fpu_req_t                   push_req,
  input  logic [TAG_W-1:0]           push_tag,
  input  logic                       pop,
  output fpu_req_t                   head_req,
  output logic [TAG_W-1:0]           head_tag,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    fpu_req_t         req;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign head_req = mem_q[rd_ptr_q].req;
  assign head_tag = mem_q[rd_ptr_q].tag;

  // NOTE: every variable driven here gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointers wrap by natural overflow.
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge value of every other register, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only read
  // after it was written, and leaving it out of reset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= '{req: push_req, tag: push_tag};
  end

endmodule

// File: rtl/fpu_issue_queue.sv
// ---------------------------------------------------------------------------
// fpu_issue_queue
//   Front-end for the non-stallable FPU pipeline. Requests are buffered in
//   fpu_req_fifo and issued one per cycle; a FPU_LATENCY-deep tag shift
//   register follows each issued op so its result can be captured on the
//   exact cycle the FPU presents it, and returned in issue order.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   in_valid/in_ready           request handshake
//   in_A, in_B, in_sel,         request operands, opcode, rounding mode,
//   in_round, in_tag            and requester tag
//   fpu_A, fpu_B, fpu_sel,      registered issue to the FPU; fpu_start is a
//   fpu_round_mode, fpu_start   one-cycle strobe per op
//   fpu_Y, fpu_overflow,        FPU result, valid FPU_LATENCY cycles after
//   fpu_error                   the matching fpu_start cycle
//   out_valid, out_Y,           one-cycle tagged result strobe, no
//   out_overflow, out_error,    backpressure
//   out_tag
//   busy                        work queued or in flight
// ---------------------------------------------------------------------------
module fpu_issue_queue
  import fpu_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int FPU_LATENCY = 6,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_A,
  input  logic [31:0]      in_B,
  input  logic [1:0]       in_sel,
  input  logic [1:0]       in_round,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      fpu_A,
  output logic [31:0]      fpu_B,
  output logic [1:0]       fpu_sel,
  output logic [1:0]       fpu_round_mode,
  output logic             fpu_start,
  input  logic [31:0]      fpu_Y,
  input  logic             fpu_overflow,
  input  logic             fpu_error,
  output logic             out_valid,
  output logic [31:0]      out_Y,
  output logic             out_overflow,
  output logic             out_error,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } trk_t;

  fpu_req_t         in_req, head_req;
  logic [TAG_W-1:0] head_tag;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CNT_W-1:0] fifo_count;

  fpu_req_t         issue_req_q, issue_req_d;
  logic [TAG_W-1:0] issue_tag_q, issue_tag_d;
  logic             fpu_start_q, fpu_start_d;

  trk_t             trk_q [FPU_LATENCY];
  trk_t             trk_d [FPU_LATENCY];
  trk_t             trk_last;
  logic             trk_any;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_y_q, out_y_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_err_q, out_err_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  // ---------------- request FIFO ----------------
  assign in_req = '{a: in_A, b: in_B, sel: fpu_op_e'(in_sel),
                    round: fpu_rnd_e'(in_round)};

  // Ready comes from registered occupancy only: a full FIFO refuses a push
  // even when it is draining this cycle.
  assign in_ready  = ~fifo_full;
  assign fifo_push = in_valid & in_ready;
  // The FPU never stalls, so the head is issued whenever one exists.
  assign fifo_pop  = ~fifo_empty;

  fpu_req_fifo #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_req (in_req),
    .push_tag (in_tag),
    .pop      (fifo_pop),
    .head_req (head_req),
    .head_tag (head_tag),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // ---------------- issue register ----------------
  always_comb begin
    issue_req_d = issue_req_q;
    issue_tag_d = issue_tag_q;
    fpu_start_d = fifo_pop;
    if (fifo_pop) begin
      issue_req_d = head_req;
      issue_tag_d = head_tag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_req_q <= '0;
      issue_tag_q <= '0;
      fpu_start_q <= 1'b0;
    end else begin
      issue_req_q <= issue_req_d;
      issue_tag_q <= issue_tag_d;
      fpu_start_q <= fpu_start_d;
    end
  end

  assign fpu_A          = issue_req_q.a;
  assign fpu_B          = issue_req_q.b;
  assign fpu_sel        = issue_req_q.sel;
  assign fpu_round_mode = issue_req_q.round;
  assign fpu_start      = fpu_start_q;

  // ---------------- in-flight tracker ----------------
  // Stage k holds the op issued k+1 cycles ago, so the last stage lines up
  // with the cycle in which the FPU presents that op's result.
  always_comb begin
    trk_d[0] = '{valid: fpu_start_q, tag: issue_tag_q};
    for (int i = 1; i < FPU_LATENCY; i++) trk_d[i] = trk_q[i-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FPU_LATENCY; i++) trk_q[i] <= '0;
    end else begin
      trk_q <= trk_d;
    end
  end

  always_comb begin
    trk_any = 1'b0;
    for (int i = 0; i < FPU_LATENCY; i++) trk_any = trk_any | trk_q[i].valid;
  end

  assign trk_last = trk_q[FPU_LATENCY-1];

  // ---------------- result capture ----------------
  always_comb begin
    out_valid_d = trk_last.valid;
    out_y_d     = out_y_q;
    out_ovf_d   = out_ovf_q;
    out_err_d   = out_err_q;
    out_tag_d   = out_tag_q;
    if (trk_last.valid) begin
      out_y_d   = fpu_Y;
      out_ovf_d = fpu_overflow;
      out_err_d = fpu_error;
      out_tag_d = trk_last.tag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_ovf_q   <= 1'b0;
      out_err_q   <= 1'b0;
      out_tag_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_ovf_q   <= out_ovf_d;
      out_err_q   <= out_err_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_Y        = out_y_q;
  assign out_overflow = out_ovf_q;
  assign out_error    = out_err_q;
  assign out_tag      = out_tag_q;

  assign busy = (fifo_count != '0) | trk_any | fpu_start_q;

endmodule

// File: tb/tb_fpu_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_fpu_issue_queue
//   Directed and random stimulus for fpu_issue_queue with a latency-6 FPU
//   model. Expected results come from a queue of accepted requests, each
//   evaluated with real arithmetic; a separate fpu_req_fifo instance covers
//   the full boundary that the top level never reaches.
// ---------------------------------------------------------------------------
module tb_fpu_issue_queue;
  import fpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = 6;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      y;
    logic             ovf;
    logic             err;
  } exp_t;

  typedef struct packed {
    logic v;
    exp_t r;
  } fpu_res_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready;
  logic [31:0]      in_A, in_B;
  logic [1:0]       in_sel, in_round;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      fpu_A, fpu_B, fpu_Y;
  logic [1:0]       fpu_sel, fpu_round_mode;
  logic             fpu_start, fpu_overflow, fpu_error;
  logic             out_valid, out_overflow, out_error, busy;
  logic [31:0]      out_Y;
  logic [TAG_W-1:0] out_tag;

  // standalone FIFO
  logic                       f_push, f_pop, f_full, f_empty;
  fpu_req_t                   f_req, f_head_req;
  logic [TAG_W-1:0]           f_tag, f_head_tag;
  logic [$clog2(DEPTH+1)-1:0] f_count;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb [$];

  always #5 clk = ~clk;

  fpu_issue_queue #(.DEPTH(DEPTH), .FPU_LATENCY(LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_A), .in_B(in_B), .in_sel(in_sel), .in_round(in_round), .in_tag(in_tag),
    .fpu_A(fpu_A), .fpu_B(fpu_B), .fpu_sel(fpu_sel), .fpu_round_mode(fpu_round_mode),
    .fpu_start(fpu_start), .fpu_Y(fpu_Y), .fpu_overflow(fpu_overflow), .fpu_error(fpu_error),
    .out_valid(out_valid), .out_Y(out_Y), .out_overflow(out_overflow),
    .out_error(out_error), .out_tag(out_tag), .busy(busy)
  );

  fpu_req_fifo #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_fifo_chk (
    .clk(clk), .reset(reset), .push(f_push), .push_req(f_req), .push_tag(f_tag),
    .pop(f_pop), .head_req(f_head_req), .head_tag(f_head_tag),
    .full(f_full), .empty(f_empty), .count(f_count)
  );

  // ---------------- reference arithmetic ----------------
  // Operands are kept normal, so single<->double is a re-bias of the exponent
  // and a shift of the mantissa (results truncated back to single).
  function automatic logic [63:0] sp2dp(input logic [31:0] x);
    logic [10:0] e;
    e = {3'b000, x[30:23]} + 11'd896;
    return {x[31], e, x[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] dp2sp(input logic [63:0] d);
    logic [10:0] e;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic exp_t ref_result(input logic [31:0] a, input logic [31:0] b,
                                      input logic [1:0] sel, input logic [TAG_W-1:0] tag);
    real  ra, rb, ry;
    exp_t r;
    ra = $bitstoreal(sp2dp(a));
    rb = $bitstoreal(sp2dp(b));
    case (sel)
      FPU_OP_ADD: ry = ra + rb;
      FPU_OP_SUB: ry = ra - rb;
      FPU_OP_MUL: ry = ra * rb;
      default:    ry = ra / rb;
    endcase
    r.tag = tag;
    r.y   = dp2sp($realtobits(ry));
    r.ovf = (sel == FPU_OP_DIV);
    r.err = a[0] ^ b[0];
    return r;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    e = 8'(110 + $urandom_range(0, 30));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // ---------------- FPU model: fixed latency LAT ----------------
  fpu_res_t fpu_pipe [LAT];
  always @(posedge clk) begin
    fpu_pipe[0] <= '{v: fpu_start, r: ref_result(fpu_A, fpu_B, fpu_sel, '0)};
    for (int i = 1; i < LAT; i++) fpu_pipe[i] <= fpu_pipe[i-1];
  end
  assign fpu_Y        = (fpu_pipe[LAT-1].v === 1'b1) ? fpu_pipe[LAT-1].r.y : 32'hDEAD_BEEF;
  assign fpu_overflow = (fpu_pipe[LAT-1].v === 1'b1) ? fpu_pipe[LAT-1].r.ovf : 1'b1;
  assign fpu_error    = (fpu_pipe[LAT-1].v === 1'b1) ? fpu_pipe[LAT-1].r.err : 1'b1;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Every returned result must be the oldest outstanding accepted request.
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_tag", 64'(out_tag), 64'(e.tag));
        check("out_Y", 64'(out_Y), 64'(e.y));
        check("out_overflow", 64'(out_overflow), 64'(e.ovf));
        check("out_error", 64'(out_error), 64'(e.err));
      end
    end
  end

  // Presents a request for the coming edge; records it if it will be taken.
  task automatic drive_req(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel,
                           input logic [1:0] rnd, input logic [TAG_W-1:0] tag);
    in_valid = 1'b1;
    in_A = a; in_B = b; in_sel = sel; in_round = rnd; in_tag = tag;
    if (in_ready === 1'b1) sb.push_back(ref_result(a, b, sel, tag));
  endtask

  task automatic drive_idle();
    in_valid = 1'b0;
  endtask

  initial begin
    int peak;
    int cyc;
    reset = 1'b1;
    in_valid = 1'b0; in_A = '0; in_B = '0; in_sel = '0; in_round = '0; in_tag = '0;
    f_push = 1'b0; f_pop = 1'b0; f_req = '0; f_tag = '0;
    repeat (2) @(negedge clk);

    // ---- reset values ----
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_fpu_start", 64'(fpu_start), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_Y", 64'(out_Y), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // ---- standalone FIFO: full boundary ----
    check("fifo_empty0", 64'(f_empty), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      f_push = 1'b1; f_tag = TAG_W'(i); f_req = '0; f_req.a = 32'(i) * 32'h1111_1111;
      @(negedge clk);
      check("fifo_fill_count", 64'(f_count), 64'(i));
      check("fifo_fill_full", 64'(f_full), 64'(i == 4));
    end
    check("fifo_head_a", 64'(f_head_req.a), 64'h1111_1111);
    // Push while full and popping: the push is refused, the pop still happens.
    f_push = 1'b1; f_tag = 4'd5; f_pop = 1'b1;
    @(negedge clk);
    check("fifo_fullpush_count", 64'(f_count), 64'd3);
    check("fifo_fullpush_head", 64'(f_head_tag), 64'd2);
    f_push = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      check("fifo_drain_tag", 64'(f_head_tag), 64'(i));
      @(negedge clk);
    end
    f_pop = 1'b0;
    check("fifo_drain_empty", 64'(f_empty), 64'd1);
    check("fifo_drain_count", 64'(f_count), 64'd0);

    // ---- single add: accept at E0, start after E1, out_valid after E8 ----
    drive_req(32'h3F80_0000, 32'h4000_0000, FPU_OP_ADD, FPU_RND_NEAREST_EVEN, 4'd5);
    check("single_accept_ready", 64'(in_ready), 64'd1);
    for (int n = 0; n <= 9; n++) begin
      @(negedge clk);
      drive_idle();
      check("single_fpu_start", 64'(fpu_start), 64'(n == 1));
      check("single_out_valid", 64'(out_valid), 64'(n == 8));
      if (n == 1) begin
        check("single_fpu_A", 64'(fpu_A), 64'h3F80_0000);
        check("single_fpu_B", 64'(fpu_B), 64'h4000_0000);
        check("single_fpu_sel", 64'(fpu_sel), 64'd0);
      end
      if (n == 0) check("single_busy", 64'(busy), 64'd1);
      if (n == 8) begin
        check("single_out_Y", 64'(out_Y), 64'h4040_0000);
        check("single_out_tag", 64'(out_tag), 64'd5);
      end
    end
    check("single_idle", 64'(busy), 64'd0);

    // ---- burst of 4, in_valid held ----
    for (int n = 0; n < 14; n++) begin
      if (n < 4) begin
        check("burst_in_ready", 64'(in_ready), 64'd1);
        drive_req(rand_fp(), rand_fp(), 2'(n), 2'(n), TAG_W'(n));
      end else begin
        drive_idle();
      end
      @(negedge clk);
      check("burst_fpu_start", 64'(fpu_start), 64'(n >= 1 && n <= 4));
      check("burst_out_valid", 64'(out_valid), 64'(n >= 8 && n <= 11));
      if (n >= 8 && n <= 11) check("burst_out_tag", 64'(out_tag), 64'(n - 8));
    end

    // ---- back-to-back requests: issue keeps up, FIFO never fills ----
    peak = 0;
    for (int n = 0; n < 12; n++) begin
      if (n < 5) begin
        check("fill_in_ready", 64'(in_ready), 64'd1);
        drive_req(rand_fp(), rand_fp(), 2'($urandom), 2'($urandom), TAG_W'(n + 10));
      end else begin
        drive_idle();
      end
      @(negedge clk);
      if (int'(dut.u_fifo.count) > peak) peak = int'(dut.u_fifo.count);
    end
    check("fill_peak_count", 64'(peak), 64'd1);
    repeat (4) @(negedge clk);

    // ---- flag pass-through: only the div (tag 9) reports overflow ----
    for (int n = 0; n < 12; n++) begin
      if (n == 0)      drive_req(rand_fp(), rand_fp(), FPU_OP_ADD, FPU_RND_TO_ZERO, 4'd8);
      else if (n == 1) drive_req(rand_fp(), rand_fp(), FPU_OP_DIV, FPU_RND_UP, 4'd9);
      else if (n == 2) drive_req(rand_fp(), rand_fp(), FPU_OP_MUL, FPU_RND_DOWN, 4'd10);
      else             drive_idle();
      @(negedge clk);
      check("flag_out_valid", 64'(out_valid), 64'(n >= 8 && n <= 10));
      check("flag_overflow", 64'(out_valid & out_overflow), 64'(n == 9));
    end

    // ---- random traffic ----
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) != 0)
        drive_req(rand_fp(), rand_fp(), 2'($urandom), 2'($urandom), TAG_W'($urandom));
      else
        drive_idle();
      @(negedge clk);
    end
    drive_idle();
    cyc = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("random_drain_timeout", 64'(cyc < 100), 64'd1);
    check("random_sb_empty", 64'(sb.size()), 64'd0);

    // ---- reset mid-operation discards queued and in-flight ops ----
    for (int n = 0; n < 6; n++) begin
      drive_req(rand_fp(), rand_fp(), 2'($urandom), 2'($urandom), TAG_W'(n));
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    sb.delete();
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_Y", 64'(out_Y), 64'd0);
    check("midrst_out_tag", 64'(out_tag), 64'd0);
    check("midrst_flags", 64'({out_overflow, out_error}), 64'd0);
    check("midrst_fpu_start", 64'(fpu_start), 64'd0);
    check("midrst_fpu_A", 64'(fpu_A), 64'd0);
    check("midrst_fpu_B", 64'(fpu_B), 64'd0);
    check("midrst_fpu_ctl", 64'({fpu_sel, fpu_round_mode}), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    drive_idle();
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      check("postrst_out_valid", 64'(out_valid), 64'd0);
      check("postrst_fpu_start", 64'(fpu_start), 64'd0);
    end
    check("postrst_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
